// File: rtl/tx_module_if.sv
// Transmit-side bundle between the command/response logic and the UART
// transmitter. The parameter must match the transmitter's NUM_BYTES.
//
// Handshake: the master raises tx_en_sig for one clk with tx_data/tx_len
// valid in the same cycle. The request is taken only when the transmitter
// is idle (tx_busy=0) and tx_len!=0. Requests while tx_busy=1 are dropped,
// not queued. tx_busy rises on the accepting edge and stays high until the
// last stop bit ends. On that edge Tx_Donesig pulses for one cycle. A request
// made in the Tx_Donesig cycle is accepted on the next edge.
interface tx_module_if #(
    parameter int NUM_BYTES = 6
);
    logic                   tx_en_sig;
    logic [NUM_BYTES*8-1:0] tx_data;
    logic [2:0]             tx_len;
    logic                   txd;
    logic                   tx_busy;
    logic                   Tx_Donesig;
    logic                   BPS_clk;
    logic [1:0]             dbg_state;

    modport master (
        output tx_en_sig, tx_data, tx_len,
        input  txd, tx_busy, Tx_Donesig, BPS_clk, dbg_state
    );

    modport slave (
        input  tx_en_sig, tx_data, tx_len,
        output txd, tx_busy, Tx_Donesig, BPS_clk, dbg_state
    );
endinterface

// File: rtl/tx_module.sv
// 8N1-style UART transmitter. It serialises 1..NUM_BYTES payload bytes onto
// txd, byte 0 first and LSB first. The bit timing matches the receive path.
// Supported settings: CLKS_PER_BIT 4..65535, NUM_BYTES 1..7, STOP_BITS 1 or 2.
module tx_module #(
    parameter int CLKS_PER_BIT = 1433,
    parameter int NUM_BYTES    = 6,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    tx_module_if.slave  bus
);

    localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_MID   = 16'(CLKS_PER_BIT / 2);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [2:0]  MAX_LEN   = 3'(NUM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state;
    logic [15:0]            baud_cnt;
    logic [2:0]             bit_idx;     // data bit in DATA, stop bit in STOP
    logic [2:0]             byte_idx;
    logic [2:0]             last_byte;   // latched effective length - 1
    logic [7:0]             shift_q;     // current byte, shifted out LSB first
    logic [NUM_BYTES*8-1:0] pay_q;       // payload; byte 0 always in the low bits
    logic                   txd_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   bps_q;

    logic                   bit_end;
    logic [2:0]             eff_len;
    logic [NUM_BYTES*8-1:0] pay_next;

    // Bit boundary, length clamp and next-byte alignment for the FSM.
    always_comb begin
        bit_end  = (baud_cnt == CNT_MAX);
        eff_len  = (bus.tx_len > MAX_LEN) ? MAX_LEN : bus.tx_len;
        pay_next = pay_q >> 8;
    end

    // Frame FSM, baud counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 3'd0;
            last_byte <= 3'd0;
            shift_q   <= 8'd0;
            pay_q     <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bps_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // The pulse lands in the cycle after the mid-bit count.
            bps_q  <= (state != IDLE) && (baud_cnt == CNT_MID);

            // The counter runs only inside a frame. It wraps at every bit end.
            if (state != IDLE) begin
                baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.tx_en_sig && (bus.tx_len != 3'd0)) begin
                        pay_q     <= bus.tx_data;
                        shift_q   <= bus.tx_data[7:0];
                        last_byte <= eff_len - 3'd1;
                        byte_idx  <= 3'd0;
                        bit_idx   <= 3'd0;
                        baud_cnt  <= 16'd0;
                        txd_q     <= 1'b0;   // the start bit begins on this edge
                        busy_q    <= 1'b1;
                        state     <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= 3'd0;
                        txd_q   <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= 3'd0;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_q   <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        if (bit_idx != LAST_STOP) begin
                            bit_idx <= bit_idx + 3'd1;
                        end else if (byte_idx != last_byte) begin
                            // The next byte follows with no idle gap.
                            byte_idx <= byte_idx + 3'd1;
                            bit_idx  <= 3'd0;
                            pay_q    <= pay_next;
                            shift_q  <= pay_next[7:0];
                            txd_q    <= 1'b0;
                            state    <= START;
                        end else begin
                            bit_idx <= 3'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.txd        = txd_q;
    assign bus.tx_busy    = busy_q;
    assign bus.Tx_Donesig = done_q;
    assign bus.BPS_clk    = bps_q;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_tx_module.sv
// Bench for tx_module. It uses three instances: the default 1433-clk bit
// time, a fast 16-clk bit time with a serial receiver model, and a fast
// two-stop-bit variant.
module tb_tx_module;

    localparam int S_CPB = 1433;
    localparam int F_CPB = 16;
    localparam int NB    = 6;

    logic clk;
    logic rst_n;

    tx_module_if #(.NUM_BYTES(NB)) s_if ();
    tx_module_if #(.NUM_BYTES(NB)) f_if ();
    tx_module_if #(.NUM_BYTES(NB)) d_if ();

    tx_module #(.CLKS_PER_BIT(S_CPB), .NUM_BYTES(NB), .STOP_BITS(1)) dut_slow (
        .clk(clk), .rst_n(rst_n), .bus(s_if)
    );
    tx_module #(.CLKS_PER_BIT(F_CPB), .NUM_BYTES(NB), .STOP_BITS(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .bus(f_if)
    );
    tx_module #(.CLKS_PER_BIT(F_CPB), .NUM_BYTES(NB), .STOP_BITS(2)) dut_sb2 (
        .clk(clk), .rst_n(rst_n), .bus(d_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_bytes(input string tag);
        logic [7:0] e;
        logic [7:0] a;
        check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            if (rx_q.size() > 0) a = rx_q.pop_front();
            else a = 8'hxx;
            check($sformatf("%s_byte%0d", tag, k), 64'(a), 64'(e));
        end
        rx_q.delete();
    endtask

    // Serial receiver model on the fast line: centre-samples each bit.
    initial begin : fast_rx
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && f_if.txd === 1'b0) begin
                repeat (F_CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (F_CPB) @(negedge clk);
                    b[i] = f_if.txd;
                end
                repeat (F_CPB) @(negedge clk);
                if (f_if.txd !== 1'b1) rx_err++;
                rx_q.push_back(b);
            end
        end
    end

    // Expected line level c cycles after the accept edge.
    function automatic logic exp_txd(input logic [47:0] bytes, input int cpb,
                                     input int sb, input int c);
        int         per;
        int         pos;
        logic [7:0] b;
        per = (9 + sb) * cpb;
        pos = (c % per) / cpb;
        b   = bytes[(c / per) * 8 +: 8];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos - 1];
        return 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_fast(input logic [47:0] data, input logic [2:0] len);
        @(negedge clk);
        f_if.tx_data   = data;
        f_if.tx_len    = len;
        f_if.tx_en_sig = 1'b1;
        @(negedge clk);
        f_if.tx_en_sig = 1'b0;
    endtask

    task automatic wait_done_fast(input int budget, output int cyc);
        cyc = 0;
        while (f_if.Tx_Donesig !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [47:0] data;
        logic [2:0]  len;
        int          n_bytes;
        int          cycles;
        logic [47:0] bytes;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        int err_a;
        int err_b;
        int err_c;
        int bps_n;

        vecs[0] = '{48'h06_05_04_03_02_01, 3'd6, 6, 960, 48'h06_05_04_03_02_01};
        vecs[1] = '{48'h00_00_00_00_00_3C, 3'd1, 1, 160, 48'h00_00_00_00_00_3C};
        vecs[2] = '{48'hF0_E1_D2_C3_B4_A5, 3'd7, 6, 960, 48'hF0_E1_D2_C3_B4_A5};
        vecs[3] = '{48'h12_34_56_78_FF_00, 3'd2, 2, 320, 48'h00_00_00_00_FF_00};
        vecs[4] = '{48'hAA_AA_AA_81_7E_55, 3'd3, 3, 480, 48'h00_00_00_81_7E_55};

        rst_n = 1'b0;
        s_if.tx_en_sig = 1'b0; s_if.tx_data = '0; s_if.tx_len = 3'd0;
        f_if.tx_en_sig = 1'b0; f_if.tx_data = '0; f_if.tx_len = 3'd0;
        d_if.tx_en_sig = 1'b0; d_if.tx_data = '0; d_if.tx_len = 3'd0;

        // ---- reset state and idle hold ----
        repeat (5) @(negedge clk);
        check("rst_txd",   64'(s_if.txd), 64'd1);
        check("rst_busy",  64'(s_if.tx_busy), 64'd0);
        check("rst_done",  64'(s_if.Tx_Donesig), 64'd0);
        check("rst_bps",   64'(s_if.BPS_clk), 64'd0);
        check("rst_state", 64'(s_if.dbg_state), 64'd0);
        rst_n = 1'b1;
        err_a = 0;
        repeat (5000) begin
            @(negedge clk);
            if (s_if.txd !== 1'b1 || s_if.tx_busy !== 1'b0 || s_if.Tx_Donesig !== 1'b0 ||
                s_if.BPS_clk !== 1'b0) err_a++;
            if (f_if.txd !== 1'b1 || f_if.tx_busy !== 1'b0 || f_if.Tx_Donesig !== 1'b0 ||
                f_if.BPS_clk !== 1'b0) err_a++;
        end
        check("idle_hold_errs", 64'(err_a), 64'd0);

        // ---- single byte A5 at the default bit time ----
        @(negedge clk);
        s_if.tx_data = 48'hA5; s_if.tx_len = 3'd1; s_if.tx_en_sig = 1'b1;
        @(negedge clk);
        s_if.tx_en_sig = 1'b0;
        err_a = 0; err_b = 0; err_c = 0; bps_n = 0;
        for (int c = 0; c < S_CPB * 10; c++) begin
            if (c > 0) @(negedge clk);
            if (s_if.txd !== exp_txd(48'hA5, S_CPB, 1, c)) err_a++;
            if (s_if.BPS_clk === 1'b1) begin
                bps_n++;
                if ((c % S_CPB) != 717) err_b++;
            end
            if (s_if.tx_busy !== 1'b1 || s_if.Tx_Donesig !== 1'b0) err_c++;
        end
        @(negedge clk);
        check("slow_txd_errs",  64'(err_a), 64'd0);
        check("slow_bps_count", 64'(bps_n), 64'd10);
        check("slow_bps_pos",   64'(err_b), 64'd0);
        check("slow_busy_errs", 64'(err_c), 64'd0);
        check("slow_done",      64'(s_if.Tx_Donesig), 64'd1);
        check("slow_busy_end",  64'(s_if.tx_busy), 64'd0);
        check("slow_txd_end",   64'(s_if.txd), 64'd1);
        @(negedge clk);
        check("slow_done_1cyc", 64'(s_if.Tx_Donesig), 64'd0);

        // ---- table: multi-byte frames on the fast instance ----
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vecs[i].n_bytes; k++) exp_q.push_back(vecs[i].bytes[k*8 +: 8]);
            send_fast(vecs[i].data, vecs[i].len);
            wait_done_fast(2000, cyc);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
            compare_bytes($sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d_idle", i), 64'({f_if.tx_busy, f_if.Tx_Donesig}), 64'd0);
        end

        // ---- request while busy is dropped; data changes ignored ----
        exp_q.push_back(8'hC3); exp_q.push_back(8'h5A);
        send_fast(48'h00_00_00_00_5A_C3, 3'd2);
        repeat (50) @(negedge clk);
        f_if.tx_data = 48'hFF_FF_FF_FF_FF_FF; f_if.tx_len = 3'd6; f_if.tx_en_sig = 1'b1;
        @(negedge clk);
        f_if.tx_en_sig = 1'b0;
        wait_done_fast(2000, cyc);
        check("busy_ign_cycles", 64'(cyc + 51), 64'd320);
        compare_bytes("busy_ign");

        // ---- tx_len = 0 is ignored ----
        @(negedge clk);
        f_if.tx_len = 3'd0; f_if.tx_en_sig = 1'b1;
        @(negedge clk);
        f_if.tx_en_sig = 1'b0;
        err_a = 0;
        repeat (200) begin
            @(negedge clk);
            if (f_if.txd !== 1'b1 || f_if.tx_busy !== 1'b0 || f_if.Tx_Donesig !== 1'b0 ||
                f_if.BPS_clk !== 1'b0) err_a++;
        end
        check("len0_quiet", 64'(err_a), 64'd0);
        check("len0_state", 64'(f_if.dbg_state), 64'd0);
        check("len0_rx",    64'(rx_q.size()), 64'd0);

        // ---- back-to-back: request in the done cycle ----
        exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
        send_fast(48'h3C, 3'd1);
        wait_done_fast(2000, cyc);
        check("b2b_first_cycles", 64'(cyc), 64'd160);
        check("b2b_busy_in_done", 64'(f_if.tx_busy), 64'd0);
        f_if.tx_data = 48'hC3; f_if.tx_len = 3'd1; f_if.tx_en_sig = 1'b1;
        @(negedge clk);
        f_if.tx_en_sig = 1'b0;
        check("b2b_txd_fell", 64'(f_if.txd), 64'd0);
        check("b2b_busy",     64'(f_if.tx_busy), 64'd1);
        check("b2b_done_low", 64'(f_if.Tx_Donesig), 64'd0);
        wait_done_fast(2000, cyc);
        check("b2b_second_cycles", 64'(cyc), 64'd160);
        compare_bytes("b2b");

        // ---- reset during DATA bit 3, then a clean frame ----
        send_fast(48'hF0, 3'd1);
        repeat (70) @(negedge clk);
        check("mid_state",   64'(f_if.dbg_state), 64'd2);
        check("mid_txd_low", 64'(f_if.txd), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd",   64'(f_if.txd), 64'd1);
        check("mid_rst_busy",  64'(f_if.tx_busy), 64'd0);
        check("mid_rst_state", 64'(f_if.dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        rx_q.delete();
        rx_err = 0;
        exp_q.push_back(8'h3C);
        send_fast(48'h3C, 3'd1);
        wait_done_fast(2000, cyc);
        check("post_rst_cycles", 64'(cyc), 64'd160);
        compare_bytes("post_rst");

        // ---- two stop bits: 11 bit times per byte ----
        @(negedge clk);
        d_if.tx_data = 48'hA5_3C; d_if.tx_len = 3'd2; d_if.tx_en_sig = 1'b1;
        @(negedge clk);
        d_if.tx_en_sig = 1'b0;
        err_a = 0; err_b = 0; err_c = 0;
        for (int c = 0; c < F_CPB * 22; c++) begin
            if (c > 0) @(negedge clk);
            if (d_if.txd !== exp_txd(48'hA5_3C, F_CPB, 2, c)) err_a++;
            if (d_if.BPS_clk !== ((c % F_CPB) == 9)) err_b++;
            if (d_if.tx_busy !== 1'b1 || d_if.Tx_Donesig !== 1'b0) err_c++;
        end
        @(negedge clk);
        check("sb2_txd_errs",  64'(err_a), 64'd0);
        check("sb2_bps_errs",  64'(err_b), 64'd0);
        check("sb2_busy_errs", 64'(err_c), 64'd0);
        check("sb2_done",      64'(d_if.Tx_Donesig), 64'd1);
        check("sb2_busy_end",  64'(d_if.tx_busy), 64'd0);

        check("rx_frame_errs", 64'(rx_err), 64'd0);

        // ---- final report ----
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
